// File: rtl/imuldiv_div_req_issuer_pkg.sv
// Shared types and constants for the divide request issuer: FSM encoding,
// divider fn/op encodings, command record and result-selection helpers.
package imuldiv_div_req_issuer_pkg;

    // Same fn encoding as the iterative divider request message.
    localparam logic DIV_FN_UNSIGNED = 1'b0;
    localparam logic DIV_FN_SIGNED   = 1'b1;

    localparam logic DIV_OP_QUOT = 1'b0;
    localparam logic DIV_OP_REM  = 1'b1;

    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } issuer_state_e;

    typedef struct packed {
        logic        fn;
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
    } div_cmd_t;

    // Divider responses pack {remainder, quotient}.
    function automatic logic [31:0] select_result(input logic op, input logic [63:0] resp);
        return (op == DIV_OP_REM) ? resp[63:32] : resp[31:0];
    endfunction

    // Divide by zero never reaches the divider; quotient is all ones, remainder is the dividend.
    function automatic logic [31:0] div_by_zero_result(input div_cmd_t cmd);
        return (cmd.op == DIV_OP_REM) ? cmd.a : DIV_ZERO_QUOT;
    endfunction

endpackage

// File: rtl/imuldiv_div_cmd_queue.sv
// Count-based FIFO of divide commands with val/rdy on both sides.
// No pass-through: a full queue refuses pushes even when popping.
module imuldiv_div_cmd_queue
    import imuldiv_div_req_issuer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  div_cmd_t enq_msg,
    input  logic     enq_val,
    output logic     enq_rdy,
    output div_cmd_t deq_msg,
    output logic     deq_val,
    input  logic     deq_rdy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    div_cmd_t           mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push;
    logic               pop;

    assign enq_rdy = (count_q < CNT_W'(DEPTH));
    assign deq_val = (count_q != '0);
    assign push    = enq_val && enq_rdy;
    assign pop     = deq_val && deq_rdy;
    assign deq_msg = mem[rd_ptr_q];

    // NOTE: storage is not reset; count_q alone says which entries are live,
    // so the array can map onto plain flops/RAM without a reset network.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= enq_msg;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/imuldiv_div_req_issuer.sv
// Front end for the iterative divider: queues commands, issues one divide at a
// time, short-circuits divide by zero and returns the quotient or remainder in order.
module imuldiv_div_req_issuer
    import imuldiv_div_req_issuer_pkg::*;
#(
    parameter int CMDQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cmd_msg_fn,
    input  logic        cmd_msg_op,
    input  logic [31:0] cmd_msg_a,
    input  logic [31:0] cmd_msg_b,
    input  logic        cmd_val,
    output logic        cmd_rdy,

    output logic        divreq_msg_fn,
    output logic [31:0] divreq_msg_a,
    output logic [31:0] divreq_msg_b,
    output logic        divreq_val,
    input  logic        divreq_rdy,

    input  logic [63:0] divresp_msg_result,
    input  logic        divresp_val,
    output logic        divresp_rdy,

    output logic [31:0] res_msg,
    output logic        res_val,
    input  logic        res_rdy,

    output logic        busy
);

    issuer_state_e state_q;
    div_cmd_t      opnd_q;
    logic [31:0]   result_q;

    div_cmd_t      cmd_msg;
    div_cmd_t      head_msg;
    logic          head_val;
    logic          head_rdy;

    assign cmd_msg = '{fn: cmd_msg_fn, op: cmd_msg_op, a: cmd_msg_a, b: cmd_msg_b};

    imuldiv_div_cmd_queue #(
        .DEPTH (CMDQ_DEPTH)
    ) u_cmdq (
        .clk     (clk),
        .reset   (reset),
        .enq_msg (cmd_msg),
        .enq_val (cmd_val),
        .enq_rdy (cmd_rdy),
        .deq_msg (head_msg),
        .deq_val (head_val),
        .deq_rdy (head_rdy)
    );

    // Handshake strobes decode straight from the state register: glitch-free, one cycle of latency.
    assign head_rdy    = (state_q == ST_IDLE);
    assign divreq_val  = (state_q == ST_REQ);
    assign divresp_rdy = (state_q == ST_WAIT);
    assign res_val     = (state_q == ST_RESP);

    assign divreq_msg_fn = opnd_q.fn;
    assign divreq_msg_a  = opnd_q.a;
    assign divreq_msg_b  = opnd_q.b;
    assign res_msg       = result_q;

    assign busy = (state_q != ST_IDLE) || head_val;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (head_val) begin
                        opnd_q <= head_msg;
                        if (head_msg.b == 32'd0) begin
                            result_q <= div_by_zero_result(head_msg);
                            state_q  <= ST_RESP;
                        end else begin
                            state_q  <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (divreq_rdy) state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (divresp_val) begin
                        result_q <= select_result(opnd_q.op, divresp_msg_result);
                        state_q  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (res_rdy) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imuldiv_div_req_issuer.sv
// Directed bench for imuldiv_div_req_issuer; the bench plays the divider with
// hand-computed responses and checks handshakes, latency, ordering and reset.
module tb_imuldiv_div_req_issuer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_msg_fn;
    logic        cmd_msg_op;
    logic [31:0] cmd_msg_a;
    logic [31:0] cmd_msg_b;
    logic        cmd_val;
    logic        cmd_rdy;
    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a;
    logic [31:0] divreq_msg_b;
    logic        divreq_val;
    logic        divreq_rdy;
    logic [63:0] divresp_msg_result;
    logic        divresp_val;
    logic        divresp_rdy;
    logic [31:0] res_msg;
    logic        res_val;
    logic        res_rdy;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int divreq_seen = 0;

    imuldiv_div_req_issuer #(.CMDQ_DEPTH(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .cmd_msg_fn         (cmd_msg_fn),
        .cmd_msg_op         (cmd_msg_op),
        .cmd_msg_a          (cmd_msg_a),
        .cmd_msg_b          (cmd_msg_b),
        .cmd_val            (cmd_val),
        .cmd_rdy            (cmd_rdy),
        .divreq_msg_fn      (divreq_msg_fn),
        .divreq_msg_a       (divreq_msg_a),
        .divreq_msg_b       (divreq_msg_b),
        .divreq_val         (divreq_val),
        .divreq_rdy         (divreq_rdy),
        .divresp_msg_result (divresp_msg_result),
        .divresp_val        (divresp_val),
        .divresp_rdy        (divresp_rdy),
        .res_msg            (res_msg),
        .res_val            (res_val),
        .res_rdy            (res_rdy),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (divreq_val) divreq_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic fn, input logic op, input logic [31:0] a, input logic [31:0] b);
        cmd_msg_fn = fn;
        cmd_msg_op = op;
        cmd_msg_a  = a;
        cmd_msg_b  = b;
    endtask

    // Returns #1 after the accepting edge.
    task automatic send_cmd(input string tag, input logic fn, input logic op,
                            input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        set_cmd(fn, op, a, b);
        cmd_val = 1'b1;
        while (!cmd_rdy && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_cmd_rdy"}, 32'(cmd_rdy), 32'd1);
        tick();
        cmd_val = 1'b0;
    endtask

    task automatic wait_divreq(input string tag);
        int n = 0;
        while (!divreq_val && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_divreq_val"}, 32'(divreq_val), 32'd1);
    endtask

    task automatic wait_res(input string tag);
        int n = 0;
        while (!res_val && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_res_val"}, 32'(res_val), 32'd1);
    endtask

    task automatic take_res(input string tag, input logic [31:0] exp);
        wait_res(tag);
        check({tag, "_res_msg"}, res_msg, exp);
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
    endtask

    // Full divider round trip for the request that is (or will be) at the head.
    task automatic do_div(input string tag, input logic fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] resp, input logic [31:0] exp);
        wait_divreq(tag);
        check({tag, "_fn"}, 32'(divreq_msg_fn), 32'(fn));
        check({tag, "_a"}, divreq_msg_a, a);
        check({tag, "_b"}, divreq_msg_b, b);
        divreq_rdy = 1'b1;
        tick();
        divreq_rdy = 1'b0;
        check({tag, "_divresp_rdy"}, 32'(divresp_rdy), 32'd1);
        divresp_msg_result = resp;
        divresp_val = 1'b1;
        tick();
        divresp_val = 1'b0;
        check({tag, "_res_val_next"}, 32'(res_val), 32'd1);
        take_res(tag, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_rdy"}, 32'(cmd_rdy), 32'd1);
        check({tag, "_divreq_val"}, 32'(divreq_val), 32'd0);
        check({tag, "_divresp_rdy"}, 32'(divresp_rdy), 32'd0);
        check({tag, "_res_val"}, 32'(res_val), 32'd0);
        check({tag, "_res_msg"}, res_msg, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        cmd_val = 1'b0;
        divreq_rdy = 1'b0;
        divresp_val = 1'b0;
        divresp_msg_result = 64'd0;
        res_rdy = 1'b0;
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0);

        // Reset values
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b1;
        tick();
        check_reset_outputs("rst_after");

        // Unsigned 100 / 7, remainder; latency to divreq_val
        send_cmd("u100r7", 1'b0, 1'b1, 32'd100, 32'd7);
        check("u100r7_lat_t1", 32'(divreq_val), 32'd0);
        check("u100r7_busy", 32'(busy), 32'd1);
        tick();
        check("u100r7_lat_t2", 32'(divreq_val), 32'd1);
        do_div("u100r7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 32'd2);
        check("u100r7_idle_busy", 32'(busy), 32'd0);

        // Signed -7 / 2, quotient
        send_cmd("s7q2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
        do_div("s7q2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 32'hFFFF_FFFD);

        // Divide by zero: quotient then remainder, no divider traffic
        divreq_seen = 0;
        send_cmd("dz_q", 1'b1, 1'b0, 32'd5, 32'd0);
        send_cmd("dz_r", 1'b0, 1'b1, 32'd5, 32'd0);
        take_res("dz_q", 32'hFFFF_FFFF);
        take_res("dz_r", 32'd5);
        tick();
        check("dz_no_divreq", 32'(divreq_seen), 32'd0);

        // Three back-to-back commands with stalled divider and result sink
        cmd_val = 1'b1;
        set_cmd(1'b0, 1'b0, 32'd20, 32'd3);
        tick();
        check("bb_rdy1", 32'(cmd_rdy), 32'd1);
        set_cmd(1'b0, 1'b1, 32'd50, 32'd8);
        tick();
        check("bb_rdy2", 32'(cmd_rdy), 32'd1);
        set_cmd(1'b0, 1'b0, 32'd81, 32'd9);
        tick();
        cmd_val = 1'b0;
        check("bb_rdy_full", 32'(cmd_rdy), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("bb_stall_val", 32'(divreq_val), 32'd1);
            check("bb_stall_a", divreq_msg_a, 32'd20);
            check("bb_stall_b", divreq_msg_b, 32'd3);
            tick();
        end
        divreq_rdy = 1'b1;
        tick();
        divreq_rdy = 1'b0;
        divresp_msg_result = {32'd2, 32'd6};
        divresp_val = 1'b1;
        tick();
        divresp_val = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bb_hold_val", 32'(res_val), 32'd1);
            check("bb_hold_msg", res_msg, 32'd6);
            check("bb_hold_full", 32'(cmd_rdy), 32'd0);
            tick();
        end
        take_res("bb_a", 32'd6);
        do_div("bb_b", 1'b0, 32'd50, 32'd8, {32'd2, 32'd6}, 32'd2);
        do_div("bb_c", 1'b0, 32'd81, 32'd9, {32'd0, 32'd9}, 32'd9);

        // Spurious response while idle is ignored
        tick();
        divresp_msg_result = {32'hAAAA_AAAA, 32'hBBBB_BBBB};
        divresp_val = 1'b1;
        tick();
        tick();
        tick();
        divresp_val = 1'b0;
        check("spur_res_val", 32'(res_val), 32'd0);
        check("spur_res_msg", res_msg, 32'd9);
        check("spur_busy", 32'(busy), 32'd0);

        // Reset while waiting for the divider, with one command still queued
        send_cmd("rw1", 1'b0, 1'b0, 32'd1000, 32'd10);
        send_cmd("rw2", 1'b0, 1'b0, 32'd7, 32'd7);
        wait_divreq("rw1");
        check("rw1_a", divreq_msg_a, 32'd1000);
        divreq_rdy = 1'b1;
        tick();
        divreq_rdy = 1'b0;
        check("rw_wait", 32'(divresp_rdy), 32'd1);
        reset = 1'b0;
        tick();
        check_reset_outputs("rw_rst");
        reset = 1'b1;
        divreq_seen = 0;
        tick();
        tick();
        tick();
        check("rw_post_divreq", 32'(divreq_seen), 32'd0);
        check_reset_outputs("rw_post");

        // Normal operation resumes after reset
        send_cmd("u15r4", 1'b0, 1'b1, 32'd15, 32'd4);
        do_div("u15r4", 1'b0, 32'd15, 32'd4, {32'd3, 32'd3}, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imuldiv_div_req_issuer.md
IMULDIV_DIV_REQ_ISSUER -- requirements
Module: imuldiv_div_req_issuer

Interface
REQ-001 Parameter: CMDQ_DEPTH, default 2, command-queue entries (power of two, >=2).
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 cmd_msg_fn  input  1  0 = unsigned, 1 = signed (matches the divider fn encoding).
REQ-006 cmd_msg_op  input  1  0 = return quotient, 1 = return remainder.
REQ-007 cmd_msg_a / cmd_msg_b  input  32 each  dividend / divisor.
REQ-008 cmd_val  input  1 / cmd_rdy  output  1  command handshake.
REQ-009 divreq_msg_fn  output  1; divreq_msg_a, divreq_msg_b  output  32 each  request to the iterative divider.
REQ-010 divreq_val  output  1 / divreq_rdy  input  1  divider request handshake.
REQ-011 divresp_msg_result  input  64  {remainder[63:32], quotient[31:0]}.
REQ-012 divresp_val  input  1 / divresp_rdy  output  1  divider response handshake.
REQ-013 res_msg  output  32 / res_val  output  1 / res_rdy  input  1  result handshake.
REQ-014 busy  output  1  high whenever the FSM is not IDLE or the queue is non-empty.

Function
REQ-015 Every handshake transfers exactly on the rising edge where val && rdy are both high.
REQ-016 Command queue: FIFO of {fn, op, a, b}; cmd_rdy = (count < CMDQ_DEPTH); no pass-through when full.
REQ-017 Simultaneous push and pop leave count unchanged; pointers wrap modulo CMDQ_DEPTH.
REQ-018 FSM states: IDLE, REQ, WAIT, RESP; exactly one divide outstanding.
REQ-019 IDLE: if queue non-empty, pop head into the operand register; go to RESP if b == 0, else to REQ.
REQ-020 REQ: divreq_val = 1 and divreq_msg_* driven from the operand register (stable while held); go to WAIT on divreq_val && divreq_rdy.
REQ-021 WAIT: divresp_rdy = 1; on divresp_val, capture result[63:32] if op = 1, else result[31:0], into the result register; go to RESP.
REQ-022 RESP: res_val = 1 and res_msg = result register (stable while held); go to IDLE on res_rdy.
REQ-023 Divide by zero: no divider request; quotient = 32'hFFFFFFFF (fn-independent); remainder = a.
REQ-024 divreq_val, divresp_rdy and res_val are decoded only from the state register and are never asserted outside REQ, WAIT and RESP respectively.
REQ-025 Latency: a command accepted at edge t into an empty queue with the FSM idle gives divreq_val at cycle t+2; the result gives res_val one cycle after the divresp transfer.
REQ-026 divresp_val outside WAIT is ignored (not captured, no state change).
REQ-027 Commands are accepted during REQ/WAIT/RESP while the queue is not full; results return in command order.

Reset
REQ-028 reset low at an edge: state = IDLE, queue count and pointers = 0, result register = 0.
REQ-029 During and right after reset: cmd_rdy = 1, divreq_val = 0, divresp_rdy = 0, res_val = 0, res_msg = 0, busy = 0.
REQ-030 Reset mid-operation discards the queued and in-flight commands. The divider is reset by the same reset, so no stale response remains.

Structure
REQ-031 The FSM state encodings and the fn/op constants (matching the existing divider request-message fn defines) belong in the shared imuldiv message include/package.
REQ-032 The command queue is one sub-module, imuldiv_div_cmd_queue (parameterised depth, count-based full/empty); the FSM and datapath stay in the top module.

Verification
REQ-033 Signed -7 / 2, op = 0 -> divreq fn = 1, a = 0xFFFFFFF9, b = 2; divider returns {0xFFFFFFFF, 0xFFFFFFFD} -> res_msg = 0xFFFFFFFD.
REQ-034 Unsigned 100 / 7, op = 1 -> response {2, 14} -> res_msg = 2; divreq_val first high 2 cycles after cmd accept.
REQ-035 a = 5, b = 0, op = 0 then op = 1 -> res_msg = 0xFFFFFFFF then 5; divreq_val never asserted.
REQ-036 Three back-to-back commands with divreq_rdy low for 10 cycles and res_rdy low for 5 cycles -> cmd_rdy drops after 3rd accept (depth 2, one in operand reg); divreq_msg stable; results in order.
REQ-037 Spurious divresp_val in IDLE, then reset asserted in WAIT -> no capture; after reset all outputs at reset values and queue empty.
